conv_line_buffer: RTL and testbench
===================================

CONV_LINE_BUFFER -- requirements
Module: conv_line_buffer

Interface
REQ-001 Parameter DW, default 16, pixel data width in bits.
REQ-002 Parameter IMG_W, default 220, pixels per image row.
REQ-003 Parameter IMG_H, default 220, rows per frame.
REQ-004 Parameter K, default 3, kernel size (K x K window); legal range 2 <= K <= IMG_H, K < IMG_W.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 in_valid  input  1  pixel on in_data accepted this cycle.
REQ-008 in_data  input  DW  pixel, raster order (row-major, left to right).
REQ-009 in_sof  input  1  start of frame; meaningful only with in_valid=1.
REQ-010 win_valid  output  1  win_data holds a complete, in-frame K x K window.
REQ-011 win_data  output  K*K*DW  window; element (i,j) at bits [(i*K+j)*DW +: DW].
REQ-012 frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-013 The block SHALL keep col (0..IMG_W-1) and row (0..IMG_H-1) counters of the next expected pixel, advancing only on accepted pixels.
REQ-014 All storage (line buffers, window registers) SHALL shift only on cycles with in_valid=1; with in_valid=0 all contents hold.
REQ-015 K-1 line buffers SHALL each delay their input by exactly IMG_W accepted pixels; buffer K-2 fed by in_data, buffer n fed by output of buffer n+1.
REQ-016 Window row K-1 SHALL be fed by in_data; window row i < K-1 SHALL be fed by line-buffer i output; each window row shifts left one column per accepted pixel.
REQ-017 After accepting pixel (r,c), element (i,j) SHALL equal pixel (r-K+1+i, c-K+1+j); element (K-1,K-1) is the newest pixel.
REQ-018 win_valid SHALL be 1 in the cycle after accepting pixel (r,c) with r >= K-1 and c >= K-1, else 0; latency 1 cycle, never held over idle cycles.
REQ-019 Column wrap: col IMG_W-1 -> 0, row increments; windows straddling a row boundary SHALL never be flagged valid.
REQ-020 Frame wrap: after pixel (IMG_H-1, IMG_W-1), row and col SHALL return to 0 and frame_done SHALL pulse in the same cycle as that pixel's win_valid.
REQ-021 in_sof=1 with in_valid=1 SHALL treat that pixel as (0,0) regardless of counter state; stale line-buffer data is masked by REQ-018 only.
REQ-022 in_sof on the pixel the counters already expect at (0,0) SHALL have no additional effect; back-to-back frames need no idle cycles.
REQ-023 in_sof with in_valid=0 SHALL be ignored.

Reset
REQ-024 rst=1 SHALL clear row, col, win_valid, frame_done and all window registers to 0 at the next rising edge; rst overrides in_valid.
REQ-025 Line-buffer storage is not reset; it is masked by counters per REQ-018.
REQ-026 After rst deasserts (including mid-frame), the next accepted pixel SHALL be (0,0).

Structure
REQ-027 Shared package conv_pkg SHALL hold default DW, IMG_W, IMG_H, K and a function computing counter width as clog2 of the maximum of IMG_W, IMG_H.
REQ-028 One sub-module line_delay (params DW, DEPTH; ports clk, en, d, q), enable-gated fixed-depth delay line with no reset, instantiated K-1 times.

Verification (IMG_W=8, IMG_H=6, K=3, DW=16, pixel value = row*16+col)
REQ-029 rst high 2 cycles mid-stream -> win_valid=0, frame_done=0, win_data=0; next pixel counted as (0,0).
REQ-030 Continuous frame -> first win_valid one cycle after pixel 0x22 accepted, element (0,0)=0x00, (1,1)=0x11, (2,2)=0x22; exactly 24 win_valid pulses.
REQ-031 in_valid alternating 1/0 through a frame -> identical window sequence, 24 pulses, no win_valid on idle cycles.
REQ-032 Pixels 0x30, 0x31 accepted -> win_valid=0 both; pixel 0x32 -> win_valid=1 with (0,0)=0x10.
REQ-033 Last pixel 0x57 -> win_valid=1 and frame_done=1 same cycle, (2,2)=0x57; back-to-back next frame repeats REQ-030 results.
REQ-034 in_sof at old position (2,4) -> no win_valid until new pixel (2,2); that window matches REQ-030 values.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared defaults and helpers for the convolution line buffer.
//   DEF_DW / DEF_IMG_W / DEF_IMG_H / DEF_K : default pixel width, image size, kernel size
//   cnt_width()                            : bit width of the row/col position counters
package conv_pkg;

  localparam int unsigned DEF_DW    = 16;
  localparam int unsigned DEF_IMG_W = 220;
  localparam int unsigned DEF_IMG_H = 220;
  localparam int unsigned DEF_K     = 3;

  // Counter width: clog2 of the larger image dimension (at least 1 bit)
  function automatic int unsigned cnt_width(input int unsigned w, input int unsigned h);
    int unsigned m;
    m = (w > h) ? w : h;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/line_delay.sv
// Enable-gated fixed-depth delay line (one image row of pixels), no reset.
//   clk : clock
//   en  : shift enable (one accepted pixel)
//   d   : pixel in
//   q   : pixel accepted DEPTH enables ago
module line_delay #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 220
) (
  input  logic          clk,
  input  logic          en,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  logic [DW-1:0] mem [DEPTH];

  // Shift chain; contents are masked downstream by the position counters
  always_ff @(posedge clk) begin
    if (en) begin
      mem[0] <= d;
      for (int i = 1; i < int'(DEPTH); i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  assign q = mem[DEPTH-1];

endmodule

// File: rtl/conv_line_buffer.sv
// Sliding K x K window generator over a raster-order pixel stream.
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : pixel accepted this cycle
//   in_data    : pixel value
//   in_sof     : start of frame (forces the accepted pixel to position 0,0)
//   win_valid  : win_data holds a complete in-frame window (1-cycle latency)
//   win_data   : element (i,j) at [(i*K+j)*DW +: DW]; (K-1,K-1) is the newest pixel
//   frame_done : pulse alongside the last pixel of a frame
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned IMG_W = DEF_IMG_W,
  parameter int unsigned IMG_H = DEF_IMG_H,
  parameter int unsigned K     = DEF_K
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DW-1:0]     in_data,
  input  logic              in_sof,
  output logic              win_valid,
  output logic [K*K*DW-1:0] win_data,
  output logic              frame_done
);

  localparam int unsigned CW  = cnt_width(IMG_W, IMG_H);
  localparam int unsigned NLB = K - 1;

  logic [CW-1:0] row, col;
  logic [DW-1:0] win    [K][K];
  logic [DW-1:0] lb_d   [NLB];
  logic [DW-1:0] lb_q   [NLB];
  logic [DW-1:0] row_in [K];

  logic          lb_en_c;
  logic [CW-1:0] cur_row_c, cur_col_c;
  logic          last_col_c, last_row_c, in_win_c;

  assign lb_en_c = in_valid & ~rst;

  // Line-buffer chain: the top buffer takes the live stream, each lower one the one above
  for (genvar n = 0; n < int'(NLB); n++) begin : g_lb
    if (n == int'(NLB) - 1) begin : g_head
      assign lb_d[n] = in_data;
    end else begin : g_tail
      assign lb_d[n] = lb_q[n+1];
    end

    line_delay #(
      .DW   (DW),
      .DEPTH(IMG_W)
    ) u_line_delay (
      .clk(clk),
      .en (lb_en_c),
      .d  (lb_d[n]),
      .q  (lb_q[n])
    );

    assign row_in[n] = lb_q[n];
  end

  assign row_in[K-1] = in_data;

  // Position of the pixel being accepted; sof restarts the frame at (0,0)
  assign cur_row_c  = in_sof ? '0 : row;
  assign cur_col_c  = in_sof ? '0 : col;
  assign last_col_c = (cur_col_c == CW'(IMG_W - 1));
  assign last_row_c = (cur_row_c == CW'(IMG_H - 1));
  assign in_win_c   = (cur_row_c >= CW'(K - 1)) && (cur_col_c >= CW'(K - 1));

  // Counters, flags and window shift registers
  always_ff @(posedge clk) begin
    if (rst) begin
      row        <= '0;
      col        <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      for (int i = 0; i < int'(K); i++) begin
        for (int j = 0; j < int'(K); j++) begin
          win[i][j] <= '0;
        end
      end
    end else begin
      win_valid  <= in_valid & in_win_c;
      frame_done <= in_valid & last_row_c & last_col_c;
      if (in_valid) begin
        if (last_col_c) begin
          col <= '0;
          row <= last_row_c ? '0 : cur_row_c + CW'(1);
        end else begin
          col <= cur_col_c + CW'(1);
          row <= cur_row_c;
        end
        for (int i = 0; i < int'(K); i++) begin
          for (int j = 0; j < int'(K) - 1; j++) begin
            win[i][j] <= win[i][j+1];
          end
          win[i][K-1] <= row_in[i];
        end
      end
    end
  end

  // Flatten window registers onto the output bus
  always_comb begin
    win_data = '0;
    for (int i = 0; i < int'(K); i++) begin
      for (int j = 0; j < int'(K); j++) begin
        win_data[(i*int'(K)+j)*int'(DW) +: DW] = win[i][j];
      end
    end
  end

endmodule

// File: tb/tb_conv_line_buffer.sv
module tb_conv_line_buffer;

  localparam int DW    = 16;
  localparam int IMG_W = 8;
  localparam int IMG_H = 6;
  localparam int K     = 3;
  localparam int WW    = K * K * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_sof;
  logic          win_valid;
  logic [WW-1:0] win_data;
  logic          frame_done;

  always #5 clk = ~clk;

  conv_line_buffer #(
    .DW   (DW),
    .IMG_W(IMG_W),
    .IMG_H(IMG_H),
    .K    (K)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_sof    (in_sof),
    .win_valid (win_valid),
    .win_data  (win_data),
    .frame_done(frame_done)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: image as written in the current frame plus the model's position
  logic [DW-1:0] img [IMG_H][IMG_W];
  int            mr = 0, mc = 0;
  logic          ev, ed;
  logic [WW-1:0] ew;

  // Apply one cycle of input (called at a negedge); returns at the next negedge with
  // ev/ed/ew holding what the outputs must show for that cycle.
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic s);
    in_valid = v;
    in_data  = d;
    in_sof   = s;
    @(negedge clk);
    ev = 1'b0;
    ed = 1'b0;
    if (v) begin
      if (s) begin
        mr = 0;
        mc = 0;
      end
      img[mr][mc] = d;
      ev = (mr >= K - 1) && (mc >= K - 1);
      ed = (mr == IMG_H - 1) && (mc == IMG_W - 1);
      if (ev) begin
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++)
            ew[(i*K+j)*DW +: DW] = img[mr-K+1+i][mc-K+1+j];
      end
      mc++;
      if (mc == IMG_W) begin
        mc = 0;
        mr = (mr == IMG_H - 1) ? 0 : mr + 1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sof = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (win_valid !== 1'b0 || frame_done !== 1'b0 || win_data !== '0) begin
      bad++;
      $display("FAIL reset_init: valid=%b done=%b data=%h required 0/0/0", win_valid, frame_done, win_data);
    end
    rst = 1'b0;
    for (int p = 0; p < 13; p++) drive(1'b1, DW'((p / IMG_W) * 16 + (p % IMG_W)), 1'b0);
    // reset held two cycles while the stream keeps presenting pixels
    rst = 1'b1; in_valid = 1'b1; in_data = 16'h00aa;
    repeat (2) @(negedge clk);
    total++;
    if (win_valid !== 1'b0 || frame_done !== 1'b0 || win_data !== '0) begin
      bad++;
      $display("FAIL reset_mid: valid=%b done=%b data=%h required 0/0/0", win_valid, frame_done, win_data);
    end
    rst = 1'b0;
    mr = 0;
    mc = 0;
  endtask

  task automatic test_frame(input bit gap, input bit sof_first);
    int pulses;
    logic [DW-1:0] e00, e11, e22;
    pulses = 0;
    for (int r = 0; r < IMG_H; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        if (gap) begin
          drive(1'b0, DW'($urandom), 1'($urandom % 2));
          total++;
          if (win_valid !== 1'b0 || frame_done !== 1'b0) begin
            bad++;
            $display("FAIL idle_flags r%0d c%0d: valid=%b done=%b required 0/0", r, c, win_valid, frame_done);
          end
        end
        drive(1'b1, DW'(r * 16 + c), sof_first && r == 0 && c == 0);
        if (win_valid === 1'b1) pulses++;
        total++;
        if (win_valid !== ev) begin
          bad++;
          $display("FAIL frame_valid r%0d c%0d: got %b required %b", r, c, win_valid, ev);
        end
        total++;
        if (frame_done !== ed) begin
          bad++;
          $display("FAIL frame_done r%0d c%0d: got %b required %b", r, c, frame_done, ed);
        end
        if (ev) begin
          total++;
          if (win_data !== ew) begin
            bad++;
            $display("FAIL frame_win r%0d c%0d: got %h required %h", r, c, win_data, ew);
          end
        end
        e00 = win_data[0 +: DW];
        e11 = win_data[4*DW +: DW];
        e22 = win_data[8*DW +: DW];
        if (r == 2 && c == 2) begin
          total++;
          if (win_valid !== 1'b1 || e00 !== 16'h00 || e11 !== 16'h11 || e22 !== 16'h22) begin
            bad++;
            $display("FAIL first_win: valid=%b e00=%h e11=%h e22=%h required 1/00/11/22", win_valid, e00, e11, e22);
          end
        end
        if (r == 3 && c < 2) begin
          total++;
          if (win_valid !== 1'b0) begin
            bad++;
            $display("FAIL row_straddle c%0d: valid=%b required 0", c, win_valid);
          end
        end
        if (r == 3 && c == 2) begin
          total++;
          if (win_valid !== 1'b1 || e00 !== 16'h10) begin
            bad++;
            $display("FAIL row3_first: valid=%b e00=%h required 1/10", win_valid, e00);
          end
        end
        if (r == IMG_H - 1 && c == IMG_W - 1) begin
          total++;
          if (win_valid !== 1'b1 || frame_done !== 1'b1 || e22 !== 16'h57) begin
            bad++;
            $display("FAIL last_pixel: valid=%b done=%b e22=%h required 1/1/57", win_valid, frame_done, e22);
          end
        end
      end
    end
    total++;
    if (pulses !== 24) begin
      bad++;
      $display("FAIL pulse_count: got %0d required 24", pulses);
    end
  endtask

  task automatic test_continuous();
    test_frame(1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    test_frame(1'b0, 1'b1);
  endtask

  task automatic test_gaps();
    test_frame(1'b1, 1'b0);
  endtask

  task automatic test_sof_mid();
    // stop with the counters expecting (2,4), then restart the frame
    for (int p = 0; p < 2 * IMG_W + 4; p++) begin
      drive(1'b1, DW'((p / IMG_W) * 16 + (p % IMG_W)), 1'b0);
      total++;
      if (win_valid !== ev) begin
        bad++;
        $display("FAIL presof_valid p%0d: got %b required %b", p, win_valid, ev);
      end
    end
    test_frame(1'b0, 1'b1);
  endtask

  task automatic test_random();
    logic v, s;
    for (int n = 0; n < 400; n++) begin
      v = ($urandom % 4) != 0;
      s = ($urandom % 30) == 0;
      drive(v, DW'($urandom), s);
      total++;
      if (win_valid !== ev || frame_done !== ed) begin
        bad++;
        $display("FAIL rand_flags n%0d: valid=%b done=%b required %b/%b", n, win_valid, frame_done, ev, ed);
      end
      if (ev) begin
        total++;
        if (win_data !== ew) begin
          bad++;
          $display("FAIL rand_win n%0d: got %h required %h", n, win_data, ew);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sof = 1'b0;
    ew = '0; ev = 1'b0; ed = 1'b0;
    @(negedge clk);
    test_reset();
    test_continuous();
    test_back_to_back();
    test_gaps();
    test_sof_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
